// File: rtl/prbs_pkg.sv
// Shared types and constants for the shaped-PRBS receive checker:
// slicer state encoding, PRBS7 taps and counter widths.
package prbs_pkg;

  typedef enum logic [1:0] {
    SL_STEADY_LOW   = 2'b00,
    SL_RISING_EDGE  = 2'b01,
    SL_STEADY_HIGH  = 2'b10,
    SL_FALLING_EDGE = 2'b11
  } slicer_state_t;

  typedef enum logic {
    CHK_SEARCH = 1'b0,
    CHK_LOCKED = 1'b1
  } chk_state_t;

  localparam int SAMPLE_W       = 16;
  localparam int PRBS_LEN       = 7;
  localparam int PRBS_TAP_A     = 6;
  localparam int PRBS_TAP_B     = 5;
  localparam int BIT_CNT_W      = 32;
  localparam int ERR_CNT_W      = 16;
  localparam int EDGE_CNT_W_DEF = 8;
  localparam int FILL_W         = 3;

  // Next PRBS7 bit (x^7 + x^6 + 1) from the history register, newest bit in [0].
  function automatic logic prbs7_predict(input logic [PRBS_LEN-1:0] sr);
    return sr[PRBS_TAP_A] ^ sr[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_checker.sv
// PRBS7 lock/search checker: fills a history register from received bits,
// then predicts each bit and counts checked bits and errors while locked.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_LOSS_ERRS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bit,
  input  logic                 i_bit_valid,
  input  logic                 i_clear,
  output logic                 o_locked,
  output logic [BIT_CNT_W-1:0] o_bit_cnt,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int CONS_W = $clog2(LOCK_LOSS_ERRS + 1);
  localparam logic [CONS_W-1:0] LOSS_LIM = CONS_W'(LOCK_LOSS_ERRS);
  localparam logic [CONS_W-1:0] CONS_ONE = CONS_W'(1);

  chk_state_t            r_state;
  chk_state_t            w_state_nxt;
  logic [PRBS_LEN-1:0]   r_sr;
  logic [PRBS_LEN-1:0]   w_sr_nxt;
  logic [PRBS_LEN-1:0]   w_sr_rx;
  logic [FILL_W-1:0]     r_fill;
  logic [FILL_W-1:0]     w_fill_nxt;
  logic [CONS_W-1:0]     r_cons;
  logic [CONS_W-1:0]     w_cons_nxt;
  logic [CONS_W-1:0]     w_cons_inc;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_upd;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ERR_CNT_W-1:0]  w_err_cnt_upd;
  logic                  r_locked;
  logic                  w_pred;

  assign w_pred     = prbs7_predict(r_sr);
  assign w_sr_rx    = {r_sr[PRBS_LEN-2:0], i_bit};
  assign w_cons_inc = r_cons + CONS_ONE;

  // Checker state, history register and counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= CHK_SEARCH;
      r_sr      <= '0;
      r_fill    <= '0;
      r_cons    <= '0;
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_fill    <= w_fill_nxt;
      r_cons    <= w_cons_nxt;
      r_bit_cnt <= i_clear ? '0 : w_bit_cnt_upd;
      r_err_cnt <= i_clear ? '0 : w_err_cnt_upd;
      r_locked  <= (w_state_nxt == CHK_LOCKED);
    end
  end

  // Search/lock decisions and counter updates for one received bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_fill_nxt    = r_fill;
    w_cons_nxt    = r_cons;
    w_bit_cnt_upd = r_bit_cnt;
    w_err_cnt_upd = r_err_cnt;
    if (i_bit_valid) begin
      case (r_state)
        CHK_SEARCH: begin
          w_sr_nxt   = w_sr_rx;
          w_cons_nxt = '0;
          if (r_fill == 3'd6) begin
            w_fill_nxt = '0;
            // An all-zero history is the LFSR lock-up state; refill instead.
            if (w_sr_rx == 7'd0) begin
              w_state_nxt = CHK_SEARCH;
            end else begin
              w_state_nxt = CHK_LOCKED;
            end
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end
        CHK_LOCKED: begin
          w_sr_nxt      = {r_sr[PRBS_LEN-2:0], w_pred};
          w_bit_cnt_upd = (r_bit_cnt == '1) ? r_bit_cnt : r_bit_cnt + 32'd1;
          if (i_bit != w_pred) begin
            w_err_cnt_upd = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 16'd1;
            if (w_cons_inc == LOSS_LIM) begin
              w_state_nxt = CHK_SEARCH;
              w_fill_nxt  = '0;
              w_cons_nxt  = '0;
            end else begin
              w_cons_nxt = w_cons_inc;
            end
          end else begin
            w_cons_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = CHK_SEARCH;
          w_fill_nxt  = '0;
          w_cons_nxt  = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign o_locked  = r_locked;
  assign o_bit_cnt = r_bit_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/prbs_shaped_rx_checker.sv
// Hysteresis slicer with rise/fall time measurement, bit-strobe capture and
// PRBS7 checking for a pulse-shaped DAC sample stream.
module prbs_shaped_rx_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_LOSS_ERRS = 4,
  parameter int EDGE_CNT_W     = EDGE_CNT_W_DEF
) (
  input  logic                  dac_clk,
  input  logic                  reset_n,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  input  logic                  bit_strobe,
  input  logic [SAMPLE_W-1:0]   thr_high,
  input  logic [SAMPLE_W-1:0]   thr_low,
  input  logic                  clear_counts,
  output logic                  rx_bit,
  output logic                  rx_bit_valid,
  output logic                  prbs_locked,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [ERR_CNT_W-1:0]  bit_err_cnt,
  output logic [EDGE_CNT_W-1:0] rise_time_meas,
  output logic [EDGE_CNT_W-1:0] fall_time_meas,
  output logic [1:0]            slicer_state_dbg,
  output logic [EDGE_CNT_W-1:0] edge_counter_dbg
);

  localparam logic [EDGE_CNT_W-1:0] EDGE_ONE = EDGE_CNT_W'(1);

  slicer_state_t         r_state;
  slicer_state_t         w_state_nxt;
  logic [EDGE_CNT_W-1:0] r_edge_cnt;
  logic [EDGE_CNT_W-1:0] w_edge_cnt_nxt;
  logic [EDGE_CNT_W-1:0] w_edge_cnt_inc;
  logic [EDGE_CNT_W-1:0] r_rise;
  logic [EDGE_CNT_W-1:0] w_rise_nxt;
  logic [EDGE_CNT_W-1:0] r_fall;
  logic [EDGE_CNT_W-1:0] w_fall_nxt;
  logic                  r_rx_bit;
  logic                  r_rx_valid;
  logic                  w_at_high;
  logic                  w_at_low;
  logic                  w_slice_bit;

  assign w_at_high      = (sample_in >= thr_high);
  assign w_at_low       = (sample_in <= thr_low);
  assign w_edge_cnt_inc = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + EDGE_ONE;
  assign w_slice_bit    = (r_state == SL_STEADY_HIGH) || (r_state == SL_FALLING_EDGE);

  // Slicer state, edge counter and measurements; strobe capture of the sliced bit.
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      r_state    <= SL_STEADY_LOW;
      r_edge_cnt <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_rx_bit   <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
      r_rx_bit   <= bit_strobe ? w_slice_bit : r_rx_bit;
      r_rx_valid <= bit_strobe;
    end
  end

  // Hysteresis slicer: edges that cross both thresholds are timed, runts are dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_edge_cnt_nxt = r_edge_cnt;
    w_rise_nxt     = r_rise;
    w_fall_nxt     = r_fall;
    if (thr_low >= thr_high) begin
      w_state_nxt    = SL_STEADY_LOW;
      w_edge_cnt_nxt = '0;
    end else if (sample_valid) begin
      case (r_state)
        SL_STEADY_LOW: begin
          if (w_at_high) begin
            w_state_nxt    = SL_STEADY_HIGH;
            w_rise_nxt     = EDGE_ONE;
            w_edge_cnt_nxt = '0;
          end else if (!w_at_low) begin
            w_state_nxt    = SL_RISING_EDGE;
            w_edge_cnt_nxt = EDGE_ONE;
          end else begin
            w_edge_cnt_nxt = '0;
          end
        end
        SL_RISING_EDGE: begin
          if (w_at_high) begin
            w_state_nxt    = SL_STEADY_HIGH;
            w_rise_nxt     = w_edge_cnt_inc;
            w_edge_cnt_nxt = '0;
          end else if (w_at_low) begin
            w_state_nxt    = SL_STEADY_LOW;
            w_edge_cnt_nxt = '0;
          end else begin
            w_edge_cnt_nxt = w_edge_cnt_inc;
          end
        end
        SL_STEADY_HIGH: begin
          if (w_at_low) begin
            w_state_nxt    = SL_STEADY_LOW;
            w_fall_nxt     = EDGE_ONE;
            w_edge_cnt_nxt = '0;
          end else if (!w_at_high) begin
            w_state_nxt    = SL_FALLING_EDGE;
            w_edge_cnt_nxt = EDGE_ONE;
          end else begin
            w_edge_cnt_nxt = '0;
          end
        end
        SL_FALLING_EDGE: begin
          if (w_at_low) begin
            w_state_nxt    = SL_STEADY_LOW;
            w_fall_nxt     = w_edge_cnt_inc;
            w_edge_cnt_nxt = '0;
          end else if (w_at_high) begin
            w_state_nxt    = SL_STEADY_HIGH;
            w_edge_cnt_nxt = '0;
          end else begin
            w_edge_cnt_nxt = w_edge_cnt_inc;
          end
        end
        default: begin
          w_state_nxt    = SL_STEADY_LOW;
          w_edge_cnt_nxt = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  prbs7_checker #(
    .LOCK_LOSS_ERRS (LOCK_LOSS_ERRS)
  ) u_checker (
    .i_clk       (dac_clk),
    .i_rst_n     (reset_n),
    .i_bit       (r_rx_bit),
    .i_bit_valid (r_rx_valid),
    .i_clear     (clear_counts),
    .o_locked    (prbs_locked),
    .o_bit_cnt   (bit_cnt),
    .o_err_cnt   (bit_err_cnt)
  );

  assign rx_bit           = r_rx_bit;
  assign rx_bit_valid     = r_rx_valid;
  assign rise_time_meas   = r_rise;
  assign fall_time_meas   = r_fall;
  assign slicer_state_dbg = r_state;
  assign edge_counter_dbg = r_edge_cnt;

endmodule
